// File: rtl/uwoc_tx_pkg.sv
// Shared types and constants for the UWOC TX scheduler.
package uwoc_tx_pkg;

    localparam int unsigned RATE_W = 3;
    localparam int unsigned ERR_W  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_KICK,
        ST_WAIT_BUSY,
        ST_RUN,
        ST_GAP,
        ST_RECOVER
    } sched_state_e;

    localparam logic [ERR_W-1:0] ERR_NONE    = 2'b00;
    localparam logic [ERR_W-1:0] ERR_BUSY_TO = 2'b01;
    localparam logic [ERR_W-1:0] ERR_RUN_TO  = 2'b10;
    localparam logic [ERR_W-1:0] ERR_ABORT   = 2'b11;

endpackage

// File: rtl/uwoc_tx_scheduler_if.sv
// Control/status link between the scheduler and the TX chain.
interface uwoc_tx_scheduler_if;
    import uwoc_tx_pkg::*;

    logic              tx_start;
    logic [RATE_W-1:0] tx_rate_sel;
    logic              tx_chain_rst_n;
    logic              tx_busy;
    logic              tx_done;

    modport master (output tx_start, tx_rate_sel, tx_chain_rst_n,
                    input  tx_busy, tx_done);
    modport slave  (input  tx_start, tx_rate_sel, tx_chain_rst_n,
                    output tx_busy, tx_done);
endinterface

// File: rtl/uwoc_sched_timer.sv
// Loadable down-counter; done_c is high once the count has reached zero.
module uwoc_sched_timer #(
    parameter int unsigned W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= '0;
        else if (load)        cnt <= load_val;
        else if (cnt != '0)   cnt <= cnt - W'(1);
    end

    assign done_c = (cnt == '0);
endmodule

// File: rtl/uwoc_tx_scheduler.sv
// Session sequencer for the UWOC TX chain: settle, kick, watchdog, gap, recovery.
module uwoc_tx_scheduler
    import uwoc_tx_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned GAP_W      = 24,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned BUSY_TO    = 1024,
    parameter int unsigned RST_CYC    = 16
) (
    input  logic               clk_130M,
    input  logic               rst_n,
    input  logic               cmd_start,
    input  logic               cmd_abort,
    input  logic [RATE_W-1:0]  cfg_rate_sel,
    input  logic [CNT_W-1:0]   cfg_frames,
    input  logic [GAP_W-1:0]   cfg_gap,
    input  logic [31:0]        cfg_run_timeout,
    uwoc_tx_scheduler_if.master tx,
    output logic               sched_busy,
    output logic               sched_done,
    output logic               sched_err,
    output logic [ERR_W-1:0]   err_code,
    output logic [CNT_W-1:0]   frames_sent
);
    localparam int unsigned      WD_W   = 32;
    localparam logic [WD_W-1:0]  WD_MAX = '1;

    sched_state_e      state, state_nxt;
    logic [CNT_W-1:0]  frames_cfg;
    logic [GAP_W-1:0]  gap_cfg;
    logic [WD_W-1:0]   run_to_cfg;
    logic [WD_W-1:0]   wd_cnt, wd_inc_c;
    logic [CNT_W-1:0]  frames_inc_c;
    logic              accept_c, frame_done_c, done_set_c, err_set_c;
    logic [ERR_W-1:0]  err_val_c;
    logic              tmr_load_c, tmr_done_c;
    logic [GAP_W-1:0]  tmr_val_c;
    logic              tx_start_q, chain_rst_n_q;
    logic [RATE_W-1:0] rate_q;

    assign wd_inc_c     = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + WD_W'(1);
    assign frames_inc_c = frames_sent + CNT_W'(1);

    always_ff @(posedge clk_130M or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state plus the event strobes that feed the registered outputs.
    always_comb begin
        state_nxt    = state;
        accept_c     = 1'b0;
        frame_done_c = 1'b0;
        done_set_c   = 1'b0;
        err_set_c    = 1'b0;
        err_val_c    = ERR_NONE;
        case (state)
            ST_IDLE: if (cmd_start) begin
                accept_c  = 1'b1;
                state_nxt = ST_ARM;
            end
            ST_ARM:  if (tmr_done_c) state_nxt = ST_KICK;
            ST_KICK: state_nxt = ST_WAIT_BUSY;
            ST_WAIT_BUSY, ST_RUN: begin
                if (tx.tx_done) begin
                    frame_done_c = 1'b1;
                    if (frames_cfg != '0 && frames_inc_c == frames_cfg) begin
                        done_set_c = 1'b1;
                        state_nxt  = ST_IDLE;
                    end else begin
                        state_nxt  = ST_GAP;
                    end
                end else if (state == ST_WAIT_BUSY) begin
                    if (tx.tx_busy) begin
                        state_nxt = ST_RUN;
                    end else if (wd_inc_c >= WD_W'(BUSY_TO)) begin
                        err_set_c = 1'b1;
                        err_val_c = ERR_BUSY_TO;
                    end
                end else if (run_to_cfg != '0 && wd_inc_c >= run_to_cfg) begin
                    err_set_c = 1'b1;
                    err_val_c = ERR_RUN_TO;
                end
            end
            ST_GAP:     if (tmr_done_c) state_nxt = ST_ARM;
            ST_RECOVER: if (tmr_done_c) state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        // Abort overrides any completion or timeout seen in the same cycle.
        if (cmd_abort && state != ST_IDLE) begin
            err_set_c  = 1'b1;
            err_val_c  = ERR_ABORT;
            done_set_c = 1'b0;
        end
        if (err_set_c) state_nxt = ST_RECOVER;
    end

    // Dwell timer is loaded on entry to ARM, GAP and RECOVER; a zero gap still dwells one cycle.
    always_comb begin
        tmr_load_c = (state_nxt != state);
        tmr_val_c  = '0;
        case (state_nxt)
            ST_ARM:     tmr_val_c = GAP_W'(SETTLE_CYC - 1);
            ST_GAP:     tmr_val_c = (gap_cfg == '0) ? '0 : gap_cfg - GAP_W'(1);
            ST_RECOVER: tmr_val_c = GAP_W'(RST_CYC - 1);
            default:    tmr_load_c = 1'b0;
        endcase
    end

    uwoc_sched_timer #(.W(GAP_W)) u_timer (
        .clk      (clk_130M),
        .rst_n    (rst_n),
        .load     (tmr_load_c),
        .load_val (tmr_val_c),
        .done_c   (tmr_done_c)
    );

    // Cycles elapsed since tx_start; one counter serves both watchdogs.
    always_ff @(posedge clk_130M or negedge rst_n) begin
        if (!rst_n)                wd_cnt <= '0;
        else if (state == ST_KICK) wd_cnt <= WD_W'(1);
        else                       wd_cnt <= wd_inc_c;
    end

    always_ff @(posedge clk_130M or negedge rst_n) begin
        if (!rst_n) begin
            tx_start_q    <= 1'b0;
            chain_rst_n_q <= 1'b0;
            sched_busy    <= 1'b0;
            sched_done    <= 1'b0;
        end else begin
            tx_start_q    <= (state_nxt == ST_KICK);
            chain_rst_n_q <= (state_nxt != ST_RECOVER);
            sched_busy    <= (state_nxt != ST_IDLE);
            sched_done    <= done_set_c;
        end
    end

    always_ff @(posedge clk_130M or negedge rst_n) begin
        if (!rst_n) begin
            rate_q      <= '0;
            frames_cfg  <= '0;
            gap_cfg     <= '0;
            run_to_cfg  <= '0;
            frames_sent <= '0;
            sched_err   <= 1'b0;
            err_code    <= ERR_NONE;
        end else if (accept_c) begin
            rate_q      <= cfg_rate_sel;
            frames_cfg  <= cfg_frames;
            gap_cfg     <= cfg_gap;
            run_to_cfg  <= cfg_run_timeout;
            frames_sent <= '0;
            sched_err   <= 1'b0;
            err_code    <= ERR_NONE;
        end else begin
            if (frame_done_c) frames_sent <= frames_inc_c;
            if (err_set_c) begin
                sched_err <= 1'b1;
                err_code  <= err_val_c;
            end
        end
    end

    assign tx.tx_start       = tx_start_q;
    assign tx.tx_rate_sel    = rate_q;
    assign tx.tx_chain_rst_n = chain_rst_n_q;
endmodule
